proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Synthesizable run controller for `procesadorArm`. It replaces hand-written clock and reset sequencing with registered processor reset and clock-enable generation. It supports four modes: free-run, single-step from a push-button, N-cycle burst, and hold. It sits between the board clock/button inputs and the processor core, and exposes a retired-cycle counter for debug.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `cpu_rst` is held after any reset event; must be ≥ 1.
- `BURST_W`, 16: width of `burst_len` and of the remaining-cycle counter.
- `CYC_W`, 32: width of `cycle_count`.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: 00 free-run, 01 single-step, 10 burst, 11 hold.
- `step_btn`, in, 1: raw, asynchronous step button, active-high.
- `start`, in, 1: burst start request, sampled level.
- `burst_len`, in, `BURST_W`: burst length, captured when a burst starts.
- `soft_rst`, in, 1: synchronous request to re-reset the processor.
- `cpu_rst`, out, 1: active-high reset to the processor. Registered.
- `cpu_ce`, out, 1: clock enable to the processor. Registered.
- `busy`, out, 1: high in the RESET, RUN and BURST states.
- `done`, out, 1: one-cycle pulse when a burst completes.
- `cycle_count`, out, `CYC_W`: number of cycles with `cpu_ce` high.

## Operation
- States: RESET, IDLE, RUN, STEP, BURST.
- Async reset (`rst` = 0):
  - state goes to RESET; the reset counter loads `RST_CYCLES`.
  - `cpu_rst` = 1; `cpu_ce`, `done` = 0; `cycle_count` = 0; `busy` = 1.
- RESET:
  - `cpu_rst` = 1 and `cpu_ce` = 0; the counter decrements each cycle.
  - On the cycle the counter reaches 1, go to IDLE. `cpu_rst` is therefore high for exactly `RST_CYCLES` cycles after `rst` releases.
- `soft_rst` = 1 in any state:
  - next state is RESET and the counter reloads.
  - `cycle_count` clears and any burst in progress is abandoned without a `done` pulse.
  - `soft_rst` has the highest priority over every other input.
- IDLE: `cpu_ce` = 0.
  - mode 00: go to RUN.
  - mode 01 with a detected step edge: go to STEP.
  - mode 10 with `start` = 1: capture `burst_len`.
    - Nonzero length: go to BURST.
    - Zero length: pulse `done` for one cycle and stay in IDLE.
  - mode 11: stay in IDLE.
- RUN: `cpu_ce` = 1 every cycle while mode is 00. Any other mode returns to IDLE.
- STEP: `cpu_ce` = 1 for exactly one cycle, then return to IDLE.
  - Further step edges are ignored until IDLE is re-entered.
  - One press produces one enable cycle, however long the button is held.
- BURST: `cpu_ce` = 1 for exactly the captured number of cycles.
  - `mode`, `start` and `burst_len` changes are ignored during a burst.
  - `done` pulses on the cycle after the last enable cycle, and the state returns to IDLE.
- `start` held high re-arms a new burst only after IDLE is re-entered.
- Step detection: `step_btn` passes through a 2-FF synchronizer plus a delay FF. An edge is sync2 & ~sync3.
- `cycle_count` increments each cycle `cpu_ce` = 1 and saturates at all-ones, with no wrap.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- RUN entry: mode → 00 sampled in IDLE at edge k; `cpu_ce` is high from edge k+1.
- RUN exit: mode ≠ 00 sampled at edge k; `cpu_ce` is low from edge k+1.
- Step latency: `step_btn` first sampled high at edge k; `cpu_ce` is high for exactly the cycle after edge k+3.
- Burst: `start` sampled at edge k; `cpu_ce` is high during cycles k+1 … k+N; `done` is high during cycle k+N+1.
- `cpu_rst` falls on the same edge that IDLE is entered. `cpu_ce` can first rise one cycle later.
- `cycle_count` updates one cycle after each `cpu_ce`-high cycle.

## Structure
- Shared package `proc_run_pkg`:
  - `run_mode_t` enum: MODE_RUN = 2'b00, MODE_STEP = 2'b01, MODE_BURST = 2'b10, MODE_HOLD = 2'b11.
  - `run_state_t` enum for the five states.
- Sub-module `btn_sync_edge`: the 2-FF synchronizer plus rising-edge detector, with async active-low reset to 0. It is reusable for other board buttons.
- Top level: FSM, reset counter, burst counter, saturating cycle counter.

## Test plan
- Reset release with `RST_CYCLES` = 4: `cpu_rst` is high for exactly 4 cycles after `rst` rises, then low; `cpu_ce` = 0 throughout; `cycle_count` = 0.
- Free run for 30 cycles, mode 00 then 11: exactly 30 `cpu_ce`-high cycles; `cycle_count` = 30; `cpu_ce` low one cycle after the mode change.
- Single step, mode 01: a `step_btn` pulse held 10 cycles gives exactly one `cpu_ce` cycle 3 cycles after the first sample; three presses give `cycle_count` = 3.
- Burst, mode 10, `burst_len` = 7, `start` pulsed: 7 consecutive `cpu_ce` cycles, then `done` for 1 cycle.
  - `burst_len` = 0 gives `done` only, with no `cpu_ce`.
  - A mode change mid-burst has no effect.
- `soft_rst` at burst cycle 3 of 7: `cpu_ce` drops next cycle; `cpu_rst` is high for 4 cycles; no `done`; `cycle_count` = 0.
- Saturation with `CYC_W` = 4, free run for 20 cycles: `cycle_count` stops at 15.

Source files
------------

// File: rtl/proc_run_pkg.sv
// Shared types for the processor run controller: run modes and controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_run_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_HOLD  = 2'b11
    } run_mode_t;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_BURST = 3'd4
    } run_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes a raw asynchronous button and emits a one-cycle pulse on its rising edge.
// Latency: pulse is registered; visible after the 3rd edge following the first high sample.
// Backpressure: none; a pulse is emitted once per press regardless of hold time.
module btn_sync_edge (
    input  logic clk,
    input  logic arst_n,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchronizer, a delay flop for edge detection, and a registered edge pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the processor: registered cpu_rst/cpu_ce in free-run, step, burst and hold modes.
// Latency: all outputs registered; enable follows the sampling edge of mode/start, step edges 3 edges after the button.
// Backpressure: none; mode/start/burst_len are only acted on in IDLE, step edges outside IDLE are dropped.
module proc_run_ctrl
    import proc_run_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int BURST_W    = 16,
    parameter int CYC_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               step_btn,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               soft_rst,
    output logic               cpu_rst,
    output logic               cpu_ce,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   cycle_count
);

    localparam int RCNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RST_LOAD = RCNT_W'(RST_CYCLES);

    run_state_t         state;
    logic [RCNT_W-1:0]  rst_cnt;
    logic [BURST_W-1:0] burst_rem;
    logic               step_rise;
    run_mode_t          mode_q;

    assign mode_q = run_mode_t'(mode);

    btn_sync_edge u_step_sync (
        .clk    (clk),
        .arst_n (rst),
        .btn    (step_btn),
        .rise   (step_rise)
    );

    // Controller FSM with its reset and burst counters; every output is set on the transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            rst_cnt   <= RST_LOAD;
            burst_rem <= '0;
            cpu_rst   <= 1'b1;
            cpu_ce    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (soft_rst) begin
                // Abandons anything in flight, including a burst, without a done pulse.
                state     <= ST_RESET;
                rst_cnt   <= RST_LOAD;
                burst_rem <= '0;
                cpu_rst   <= 1'b1;
                cpu_ce    <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (rst_cnt == RCNT_W'(1)) begin
                            state   <= ST_IDLE;
                            cpu_rst <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt - RCNT_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        cpu_ce <= 1'b0;
                        case (mode_q)
                            MODE_RUN: begin
                                state  <= ST_RUN;
                                cpu_ce <= 1'b1;
                                busy   <= 1'b1;
                            end
                            MODE_STEP: begin
                                if (step_rise) begin
                                    state  <= ST_STEP;
                                    cpu_ce <= 1'b1;
                                end
                            end
                            MODE_BURST: begin
                                if (start) begin
                                    if (burst_len != '0) begin
                                        state     <= ST_BURST;
                                        burst_rem <= burst_len;
                                        cpu_ce    <= 1'b1;
                                        busy      <= 1'b1;
                                    end else begin
                                        done <= 1'b1;
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                    ST_RUN: begin
                        if (mode_q == MODE_RUN) begin
                            cpu_ce <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            cpu_ce <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    ST_STEP: begin
                        // Single enable cycle already issued; button is ignored until IDLE.
                        state  <= ST_IDLE;
                        cpu_ce <= 1'b0;
                    end
                    ST_BURST: begin
                        // burst_rem counts enable cycles still owed, including the current one.
                        if (burst_rem == BURST_W'(1)) begin
                            state  <= ST_IDLE;
                            cpu_ce <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            burst_rem <= burst_rem - BURST_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_RESET;
                        rst_cnt <= RST_LOAD;
                        cpu_rst <= 1'b1;
                        cpu_ce  <= 1'b0;
                        busy    <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Retired-cycle counter: counts enabled cycles, sticks at all-ones, cleared by soft reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (soft_rst) begin
            cycle_count <= '0;
        end else if (cpu_ce && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYC_W'(1);
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share stimulus; the second uses a 4-bit cycle counter to exercise saturation.
// Outputs are compared on every falling edge while checking is enabled.
module tb_proc_run_ctrl;

    localparam int RST_CYCLES = 4;
    localparam int BURST_W    = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [1:0]         mode = 2'b11;
    logic               step_btn = 1'b0;
    logic               start = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               soft_rst = 1'b0;

    logic        cpu_rst, cpu_ce, busy, done;
    logic [31:0] cycle_count;
    logic        cpu_rst4, cpu_ce4, busy4, done4;
    logic [3:0]  cycle_count4;

    always #5 clk = ~clk;

    proc_run_ctrl #(.RST_CYCLES(RST_CYCLES), .BURST_W(BURST_W), .CYC_W(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .start(start),
        .burst_len(burst_len), .soft_rst(soft_rst), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    proc_run_ctrl #(.RST_CYCLES(RST_CYCLES), .BURST_W(BURST_W), .CYC_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .start(start),
        .burst_len(burst_len), .soft_rst(soft_rst), .cpu_rst(cpu_rst4), .cpu_ce(cpu_ce4),
        .busy(busy4), .done(done4), .cycle_count(cycle_count4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Activity is tracked as "reset cycles left", "running", "burst with N enables left",
    // "one step just issued"; outputs follow directly from those.
    int          m_rst_left;
    bit          m_run, m_burst, m_step, m_ce, m_done, m_edge;
    int          m_left;
    int unsigned m_cnt;
    int          m_cnt4;
    bit [3:0]    hist;   // hist[i] = step_btn sampled i+1 edges ago

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rst_left = RST_CYCLES;
            m_run = 0; m_burst = 0; m_step = 0; m_ce = 0; m_done = 0;
            m_left = 0; m_cnt = 0; m_cnt4 = 0; hist = '0;
        end else begin
            // A press seen 3 edges ago that was low 4 edges ago is acted on now.
            m_edge = hist[2] & ~hist[3];
            hist   = {hist[2:0], step_btn};
            if (m_ce) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_done = 0;
            if (soft_rst) begin
                m_rst_left = RST_CYCLES;
                m_run = 0; m_burst = 0; m_step = 0; m_ce = 0;
                m_cnt = 0; m_cnt4 = 0;
            end else if (m_rst_left > 0) begin
                m_rst_left--;
                m_ce = 0;
            end else if (m_burst) begin
                if (m_left > 0) begin
                    m_ce = 1; m_left--;
                end else begin
                    m_ce = 0; m_done = 1; m_burst = 0;
                end
            end else if (m_run) begin
                if (mode == 2'b00) m_ce = 1;
                else begin m_run = 0; m_ce = 0; end
            end else if (m_step) begin
                m_step = 0; m_ce = 0;
            end else begin
                m_ce = 0;
                case (mode)
                    2'b00: begin m_run = 1; m_ce = 1; end
                    2'b01: if (m_edge) begin m_step = 1; m_ce = 1; end
                    2'b10: if (start) begin
                        if (burst_len == 0) m_done = 1;
                        else begin m_burst = 1; m_ce = 1; m_left = int'(burst_len) - 1; end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_rst_left > 0});
            chk("cpu_ce", {31'd0, cpu_ce}, {31'd0, m_ce});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("busy", {31'd0, busy}, {31'd0, (m_rst_left > 0) || m_run || m_burst});
            chk("cycle_count", cycle_count, m_cnt);
            chk("cpu_ce4", {31'd0, cpu_ce4}, {31'd0, m_ce});
            chk("cpu_rst4", {31'd0, cpu_rst4}, {31'd0, m_rst_left > 0});
            chk("done4", {31'd0, done4}, {31'd0, m_done});
            chk("busy4", {31'd0, busy4}, {31'd0, (m_rst_left > 0) || m_run || m_burst});
            chk("cycle_count4", {28'd0, cycle_count4}, m_cnt4);
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        int n, nd, done_at;
        logic [9:0] v;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_cpu_rst", {31'd0, cpu_rst}, 1);
        chk("reset_cpu_ce", {31'd0, cpu_ce}, 0);
        chk("reset_busy", {31'd0, busy}, 1);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_count", cycle_count, 0);

        // Reset release: count the rising edges that see cpu_rst high.
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (cpu_rst) n++;
            @(negedge clk);
        end
        chk("reset_release_len", n, 4);

        // Free run for 30 cycles, then hold.
        mode = 2'b00;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpu_ce) n++;
        end
        mode = 2'b11;
        @(negedge clk);
        chk("run_exit_ce", {31'd0, cpu_ce}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ce) n++;
        end
        chk("run_ce_cycles", n, 30);
        chk("run_count", cycle_count, 30);
        chk("sat_count4", {28'd0, cycle_count4}, 15);

        // Single step: three presses, each held 10 cycles.
        mode = 2'b01;
        n = 0;
        v = '0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (cpu_ce) begin
                    n++;
                    if (p == 0) v[j] = 1'b1;
                end
            end
            step_btn = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (cpu_ce) n++;
            end
        end
        chk("step_latency", {22'd0, v}, 32'b00_0000_1000);
        chk("step_ce_cycles", n, 3);
        chk("step_count", cycle_count, 33);

        // Burst of 7 with mode/start/length changes mid-burst.
        mode = 2'b10; burst_len = 16'd7; start = 1'b1;
        n = 0; nd = 0; done_at = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cpu_ce) n++;
            if (done) begin nd++; done_at = i; end
            if (i == 0) start = 1'b0;
            if (i == 2) begin mode = 2'b00; start = 1'b1; burst_len = 16'd3; end
            if (i == 4) begin mode = 2'b11; start = 1'b0; end
        end
        chk("burst_ce_cycles", n, 7);
        chk("burst_done_pulses", nd, 1);
        chk("burst_done_when", done_at, 7);
        chk("burst_count", cycle_count, 40);

        // Zero-length burst: done only.
        mode = 2'b10; burst_len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_ce", {31'd0, cpu_ce}, 0);
        @(negedge clk);
        chk("zero_done_one_cycle", {31'd0, done}, 0);

        // Soft reset on the 3rd cycle of a 7-cycle burst.
        burst_len = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        chk("soft_ce_drop", {31'd0, cpu_ce}, 0);
        chk("soft_count", cycle_count, 0);
        n = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (cpu_rst) n++;
            if (done) nd++;
            @(negedge clk);
        end
        chk("soft_rst_len", n, 4);
        chk("soft_no_done", nd, 0);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            start     = ($urandom_range(0, 7) == 0);
            burst_len = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            soft_rst  = ($urandom_range(0, 149) == 0);
            if (i == 1500) begin
                #2 rst = 1'b0;
                #1;
                chk("async_cpu_rst", {31'd0, cpu_rst}, 1);
                chk("async_cpu_ce", {31'd0, cpu_ce}, 0);
                chk("async_done", {31'd0, done}, 0);
                chk("async_busy", {31'd0, busy}, 1);
                chk("async_count", cycle_count, 0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        mode = 2'b11; start = 1'b0; soft_rst = 1'b0; step_btn = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
